// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions.
//
// Contents:
//   ANG_PI_2, ANG_PI, ANG_M_PI_2 : angle constants on a 32-bit circle
//                                  (2^32 = full turn, two's complement)
//   INV_K_Q15                    : 1/K in Q15, used to remove the CORDIC gain
//   ATAN_TABLE                   : atan(2^-i) on the same 32-bit circle, i = 0..30
//   state_e                      : control states of the vectoring engine
//   atan_entry()                 : range-safe lookup into ATAN_TABLE
//
// The angle encoding matches the sine/cosine rotator, so a phase produced
// here can be fed straight back to it.
package cordic_pkg;

  localparam logic [31:0] ANG_PI_2   = 32'h4000_0000;
  localparam logic [31:0] ANG_PI     = 32'h8000_0000;
  localparam logic [31:0] ANG_M_PI_2 = ANG_PI + ANG_PI_2;

  localparam int unsigned INV_K_Q15 = 19898;

  localparam int ATAN_N = 31;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] ATAN_TABLE [ATAN_N] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_COMP,
    S_DONE
  } state_e;

  // A 5-bit index can address 31, which is past the end of the table.
  function automatic logic [31:0] atan_entry(input logic [4:0] idx);
    logic [31:0] val;
    val = '0;
    if (int'(idx) < ATAN_N) val = ATAN_TABLE[idx];
    return val;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational CORDIC vectoring micro-rotation.
//
// Ports:
//   x_in, y_in  : current vector (signed, W bits)
//   z_in        : accumulated angle (32-bit circle)
//   shift       : iteration index i (shift amount)
//   atan_val    : atan(2^-i) on the 32-bit circle
//   x_out,y_out : rotated vector
//   z_out       : updated angle
//
// The rotation direction is chosen to drive Y toward zero. Both right-hand
// sides use the incoming X/Y, never the freshly rotated ones.
module cordic_vec_stage #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic        [31:0]  z_in,
  input  logic        [4:0]   shift,
  input  logic        [31:0]  atan_val,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic        [31:0]  z_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  always_comb begin
    x_sh  = x_in >>> shift;
    y_sh  = y_in >>> shift;
    x_out = x_in;
    y_out = y_in;
    z_out = z_in;
    if (!y_in[W-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_val;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_val;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: (x_in, y_in) -> magnitude, phase.
//
// Ports:
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_ready only while idle
//   x_in, y_in           : signed Cartesian sample, DATA_W bits
//   out_valid/out_ready  : output handshake; results held until accepted
//   magnitude            : unsigned, DATA_W+2 bits (K-scaled unless compensated)
//   phase                : 32-bit angle, 2^32 = full circle, two's complement
//
// Parameters: DATA_W (input width), ITER (micro-rotations, 1..30).
//
// Optional build macro CORDIC_GAIN_COMP_EN: adds a COMP state that multiplies
// the final X by 1/K (Q15, rounded), so magnitude approximates sqrt(x^2+y^2).
// Latency grows from ITER+1 to ITER+2 clocks.
//
// One sample is processed at a time; a single micro-rotation stage is
// reused once per clock while in ITER.
module cordic_vectoring #(
  parameter int DATA_W = 16,
  parameter int ITER   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W+1:0] magnitude,
  output logic        [31:0]       phase
);

  import cordic_pkg::*;

  // Two guard bits hold sqrt(2) * 2^(DATA_W-1) * K without overflow.
  localparam int W     = DATA_W + 2;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_e              state_q, state_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic        [31:0]  z_q, z_d;
  logic [CNT_W-1:0]    iter_q, iter_d;
  logic                zero_q, zero_d;
  logic        [W-1:0] mag_q, mag_d;
  logic        [31:0]  phase_q, phase_d;

  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] pre_x, pre_y;
  logic        [31:0]  pre_z;

  logic signed [W-1:0] stg_x, stg_y;
  logic        [31:0]  stg_z;

`ifdef CORDIC_GAIN_COMP_EN
  logic [W+15:0] comp_prod;
`endif

  cordic_vec_stage #(
    .W (W)
  ) u_stage (
    .x_in     (x_q),
    .y_in     (y_q),
    .z_in     (z_q),
    .shift    (iter_q),
    .atan_val (atan_entry(iter_q)),
    .x_out    (stg_x),
    .y_out    (stg_y),
    .z_out    (stg_z)
  );

  // Fold the left half-plane onto the right half-plane by a +/-90 degree
  // rotation so the micro-rotations only have to cover +/-90 degrees.
  always_comb begin
    x_ext = {{2{x_in[DATA_W-1]}}, x_in};
    y_ext = {{2{y_in[DATA_W-1]}}, y_in};
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = '0;
    if (x_ext < 0) begin
      if (y_ext >= 0) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = ANG_PI_2;
      end else begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = ANG_M_PI_2;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;
`ifdef CORDIC_GAIN_COMP_EN
    comp_prod = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = pre_x;
          y_d     = pre_y;
          z_d     = pre_z;
          iter_d  = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        x_d = stg_x;
        y_d = stg_y;
        z_d = stg_z;
        if (iter_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          // A zero vector still accumulates angle, so its result is forced.
          mag_d   = zero_q ? '0 : W'($unsigned(stg_x));
          phase_d = zero_q ? '0 : stg_z;
          state_d = S_DONE;
`endif
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
        // Final X is non-negative, so it is zero-extended into the product.
        comp_prod = (W+16)'($unsigned(x_q)) * (W+16)'(INV_K_Q15)
                  + (W+16)'(1 << 14);
        mag_d     = zero_q ? '0 : comp_prod[W+14:15];
        phase_d   = zero_q ? '0 : z_q;
        state_d   = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign magnitude = mag_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring.
//
// Expected results come from an ideal floating-point model: magnitude is
// |v| times the CORDIC gain of ITER rotations (or |v| with
// CORDIC_GAIN_COMP_EN), phase is atan2(y, x) on the 32-bit circle.
// Tolerances allow for the fixed-point truncation of a small-magnitude
// vector. A few literal checks pin the model to hand-derived values.
module tb_cordic_vectoring;

  localparam int  DATA_W = 16;
  localparam int  ITER   = 16;
  localparam real TWO_PI = 6.283185307179586;
  localparam real CIRCLE = 4294967296.0;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = ITER + 2;
`else
  localparam int  LAT = ITER + 1;
`endif

  typedef struct {
    real         mag;
    logic [31:0] ph;
    longint      mag_tol;
    longint      ph_tol;
  } exp_t;

  logic                     clock;
  logic                     reset_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic                     out_valid;
  logic                     out_ready;
  logic        [DATA_W+1:0] magnitude;
  logic        [31:0]       phase;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  exp_t exp_q[$];

  cordic_vectoring #(
    .DATA_W (DATA_W),
    .ITER   (ITER)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .phase     (phase)
  );

  // 100 MHz free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input bit ok,
                             input longint act, input longint exp,
                             input longint tol);
    chk_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  function automatic real absReal(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real cordicGain();
    real k, s;
    k = 1.0;
    s = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k = k * $sqrt(1.0 + s * s);
      s = s / 2.0;
    end
    return k;
  endfunction

  function automatic exp_t model(input int x, input int y);
    exp_t   e;
    real    r, ang;
    longint l;
    e.mag = 0.0; e.ph = '0; e.mag_tol = 0; e.ph_tol = 0;
    if (x == 0 && y == 0) return e;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
`ifdef CORDIC_GAIN_COMP_EN
    e.mag = r;
`else
    e.mag = r * cordicGain();
`endif
    ang       = $atan2(real'(y), real'(x));
    l         = longint'(ang * CIRCLE / TWO_PI);
    e.ph      = l[31:0];
    e.mag_tol = 3 * ITER;
    e.ph_tol  = 65536 + longint'(2.0 * ITER * CIRCLE / TWO_PI / r);
    return e;
  endfunction

  function automatic bit phaseClose(input logic [31:0] a, input logic [31:0] b,
                                    input longint tol);
    logic signed [31:0] d;
    d = a - b;
    return (longint'(d) <= tol) && (longint'(d) >= -tol);
  endfunction

  // Compare process: every cycle a result is presented it is checked against
  // the oldest outstanding model prediction; the prediction retires when the
  // consumer accepts the result.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1'b0, 1, 0, 0);
      end else begin
        checkOutput("mon_mag",
                    (absReal(real'(magnitude) - exp_q[0].mag) <= real'(exp_q[0].mag_tol)),
                    longint'(magnitude), longint'(exp_q[0].mag), exp_q[0].mag_tol);
        checkOutput("mon_phase", phaseClose(phase, exp_q[0].ph, exp_q[0].ph_tol),
                    longint'(phase), longint'(exp_q[0].ph), exp_q[0].ph_tol);
        checkOutput("mon_in_ready_low", !in_ready, longint'(in_ready), 0, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present one sample, record its prediction, and wait (bounded) for the
  // result, checking handshake-to-out_valid latency.
  task automatic applyStimulus(input int x, input int y);
    int   lat;
    int   n;
    exp_t e;
    n = 0;
    @(posedge clock); #2;
    while (!in_ready && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    x_in     = DATA_W'(x);
    y_in     = DATA_W'(y);
    in_valid = 1'b1;
    e        = model(x, y);
    @(posedge clock);
    exp_q.push_back(e);
    #2 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    checkOutput($sformatf("latency(%0d,%0d)", x, y), lat == LAT, lat, LAT, 0);
  endtask

  initial begin
    exp_t        p;
    logic [31:0] hold_mag;
    logic [31:0] hold_ph;
    int          n;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;

    // Model pins against hand-derived values.
`ifdef CORDIC_GAIN_COMP_EN
    p = model(1000, 0);
    checkOutput("pin_mag_1000_0", absReal(p.mag - 1000.0) <= 2.0, longint'(p.mag), 1000, 2);
    p = model(1000, 1000);
    checkOutput("pin_mag_1000_1000", absReal(p.mag - 1414.0) <= 2.0, longint'(p.mag), 1414, 2);
`else
    p = model(1000, 0);
    checkOutput("pin_mag_1000_0", absReal(p.mag - 1647.0) <= 2.0, longint'(p.mag), 1647, 2);
    p = model(1000, 1000);
    checkOutput("pin_mag_1000_1000", absReal(p.mag - 2329.0) <= 3.0, longint'(p.mag), 2329, 3);
`endif
    checkOutput("pin_ph_1000_1000", phaseClose(p.ph, 32'h2000_0000, 65536),
                longint'(p.ph), 32'h2000_0000, 65536);
    p = model(-1000, 0);
    checkOutput("pin_ph_m1000_0", phaseClose(p.ph, 32'h8000_0000, 65536),
                longint'(p.ph), 32'h8000_0000, 65536);
    p = model(0, -1000);
    checkOutput("pin_ph_0_m1000", phaseClose(p.ph, 32'hC000_0000, 65536),
                longint'(p.ph), 32'hC000_0000, 65536);
    p = model(-32768, -32768);
    checkOutput("pin_ph_min_min", phaseClose(p.ph, 32'hA000_0000, 65536),
                longint'(p.ph), 32'hA000_0000, 65536);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1, 0);
    checkOutput("rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0, 0);
    checkOutput("rst_magnitude", magnitude == '0, longint'(magnitude), 0, 0);
    checkOutput("rst_phase", phase == '0, longint'(phase), 0, 0);
    @(posedge clock); #2 reset_n = 1'b1;

    // Directed vectors, one per quadrant/axis plus extremes.
    applyStimulus(1000, 0);
    applyStimulus(0, 1000);
    applyStimulus(-1000, 0);
    applyStimulus(0, -1000);
    applyStimulus(1000, 1000);
    applyStimulus(-32768, -32768);
    applyStimulus(32767, -32768);
    applyStimulus(-1000, -1);
    applyStimulus(12345, -6789);
    applyStimulus(-20000, 15000);
    applyStimulus(0, 0);
    @(posedge clock); #1;
    checkOutput("zero_magnitude", magnitude == '0, longint'(magnitude), 0, 0);
    checkOutput("zero_phase", phase == '0, longint'(phase), 0, 0);

    // Backpressure: result held for 20 clocks, input pulses ignored.
    out_ready = 1'b0;
    applyStimulus(1000, 1000);
    hold_mag = 32'(magnitude);
    hold_ph  = phase;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #2;
      in_valid = k[0];
      x_in     = -16'sd7777;
      y_in     = 16'sd1234;
      #1;
      checkOutput($sformatf("hold_%0d", k),
                  out_valid && !in_ready && (32'(magnitude) == hold_mag) && (phase == hold_ph),
                  longint'(magnitude), longint'(hold_mag), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #2;
      checkOutput($sformatf("no_capture_%0d", k), !out_valid, longint'(out_valid), 0, 0);
    end
    checkOutput("idle_after_drain", in_ready == 1'b1, longint'(in_ready), 1, 0);

    // Reset in the middle of the iterations discards the sample.
    @(posedge clock); #2;
    x_in     = 16'sd3000;
    y_in     = -16'sd4000;
    in_valid = 1'b1;
    @(posedge clock); #2;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid == 1'b0, longint'(out_valid), 0, 0);
    checkOutput("midrst_in_ready", in_ready == 1'b1, longint'(in_ready), 1, 0);
    @(posedge clock); #2 reset_n = 1'b1;
    applyStimulus(-20000, 15000);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    checkOutput("queue_drained", exp_q.size() == 0, exp_q.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
